// File: rtl/spi_display_rx_pkg.sv
// Shared constants, FSM encoding and debug view for the SPI display receiver.
// Imported by the byte receiver, the top level and the testbench.
package spi_display_rx_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CASET  = 3'd1,
    ST_PASET  = 3'd2,
    ST_RAMWR  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [1:0] idx;
    logic [8:0] xs;
    logic [8:0] xe;
    logic [8:0] ys;
    logic [8:0] ye;
    logic [8:0] x;
    logic [8:0] y;
  } dbg_t;

  // Cursor step: wraps to the window start after the window end. The 9-bit add
  // also wraps through 0 when start > end.
  function automatic logic [8:0] step_coord(input logic [8:0] cur,
                                            input logic [8:0] lo,
                                            input logic [8:0] hi);
    return (cur == hi) ? lo : cur + 9'd1;
  endfunction

endpackage

// File: rtl/spi_display_rx_if.sv
// SPI bus into the display receiver: serial clock, data, data/command select
// and active-low chip select. Every signal is asynchronous to the system clock.
interface spi_display_rx_if;
  logic sclk;
  logic mosi;
  logic dc;
  logic cs;

  modport master (output sclk, output mosi, output dc, output cs);
  modport slave  (input  sclk, input  mosi, input  dc, input  cs);
endinterface

// File: rtl/spi_display_rx_byte_rx.sv
// SPI mode-0 byte deserializer: 2-flop synchronizers, rising-edge detection,
// MSB-first shift register, and an error pulse when chip select cuts a byte.
module spi_byte_rx
  import spi_display_rx_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  spi_display_rx_if.slave         spi,
  output logic                    o_byte_valid,
  output logic [7:0]              o_byte,
  output logic                    o_byte_dc,
  output logic                    o_frag_err
);

  logic       r_sclk_m, r_sclk_s, r_sclk_d;
  logic       r_mosi_m, r_mosi_s;
  logic       r_dc_m, r_dc_s;
  logic       r_cs_m, r_cs_s;
  logic [7:0] r_shift;
  logic [2:0] r_cnt;
  logic       w_rise;
  logic [7:0] w_shift_nxt;

  assign w_rise      = r_sclk_s & ~r_sclk_d;
  assign w_shift_nxt = {r_shift[6:0], r_mosi_s};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_m     <= 1'b0;
      r_sclk_s     <= 1'b0;
      r_sclk_d     <= 1'b0;
      r_mosi_m     <= 1'b0;
      r_mosi_s     <= 1'b0;
      r_dc_m       <= 1'b0;
      r_dc_s       <= 1'b0;
      r_cs_m       <= 1'b1;
      r_cs_s       <= 1'b1;
      r_shift      <= 8'h00;
      r_cnt        <= 3'd0;
      o_byte_valid <= 1'b0;
      o_byte       <= 8'h00;
      o_byte_dc    <= 1'b0;
      o_frag_err   <= 1'b0;
    end else begin
      r_sclk_m     <= spi.sclk;
      r_sclk_s     <= r_sclk_m;
      r_sclk_d     <= r_sclk_s;
      r_mosi_m     <= spi.mosi;
      r_mosi_s     <= r_mosi_m;
      r_dc_m       <= spi.dc;
      r_dc_s       <= r_dc_m;
      r_cs_m       <= spi.cs;
      r_cs_s       <= r_cs_m;
      o_byte_valid <= 1'b0;
      o_frag_err   <= 1'b0;
      // Deselect discards any partial byte; only a non-empty one is an error.
      if (r_cs_s) begin
        r_cnt      <= 3'd0;
        r_shift    <= 8'h00;
        o_frag_err <= (r_cnt != 3'd0);
      end else if (w_rise) begin
        r_shift <= w_shift_nxt;
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          o_byte_valid <= 1'b1;
          o_byte       <= w_shift_nxt;
          o_byte_dc    <= r_dc_s;
        end
      end
    end
  end

endmodule

// File: rtl/spi_display_rx.sv
// Display-controller front end: decodes CASET/PASET/RAMWR from the SPI byte
// stream and emits RGB565 pixels with their window cursor coordinates.
module spi_display_rx
  import spi_display_rx_pkg::*;
#(
  parameter int H_RES = 240,
  parameter int V_RES = 320
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  spi_display_rx_if.slave         spi,
  // o_cmd_valid / o_pix_valid are single-cycle pulses with no backpressure;
  // o_cmd and o_pix_* hold their value until the next pulse.
  output logic                    o_cmd_valid,
  output logic [7:0]              o_cmd,
  output logic                    o_pix_valid,
  output logic [8:0]              o_pix_x,
  output logic [8:0]              o_pix_y,
  output logic [15:0]             o_pix_color,
  output logic                    o_err,
  output dbg_t                    o_dbg
);

  localparam logic [9:0] H_LIM = 10'(H_RES);
  localparam logic [9:0] V_LIM = 10'(V_RES);

  logic       w_byte_valid, w_byte_dc, w_frag_err;
  logic [7:0] w_byte;
  state_t     r_state, w_state_nxt;
  logic [1:0] r_idx;
  logic [7:0] r_col_hi;
  logic [8:0] r_xs, r_xe, r_ys, r_ye, r_x, r_y;
  logic       w_is_cmd, w_is_data, w_pix_fire, w_pix_oor;
  logic [8:0] w_x_step, w_y_step;

  spi_byte_rx u_byte_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .spi          (spi),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_byte_dc    (w_byte_dc),
    .o_frag_err   (w_frag_err)
  );

  assign w_is_cmd  = w_byte_valid & ~w_byte_dc;
  assign w_is_data = w_byte_valid &  w_byte_dc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_is_cmd) begin
      case (w_byte)
        CMD_CASET: w_state_nxt = ST_CASET;
        CMD_PASET: w_state_nxt = ST_PASET;
        CMD_RAMWR: w_state_nxt = ST_RAMWR;
        default:   w_state_nxt = ST_IGNORE;
      endcase
    end else if (w_is_data && (r_idx == 2'd3) &&
                 (r_state == ST_CASET || r_state == ST_PASET)) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    w_pix_fire = w_is_data && (r_state == ST_RAMWR) && r_idx[0];
    w_pix_oor  = ({1'b0, r_x} >= H_LIM) || ({1'b0, r_y} >= V_LIM);
    w_x_step   = step_coord(r_x, r_xs, r_xe);
    w_y_step   = (r_x == r_xe) ? step_coord(r_y, r_ys, r_ye) : r_y;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx       <= 2'd0;
      r_col_hi    <= 8'h00;
      r_xs        <= 9'd0;
      r_xe        <= 9'(H_RES - 1);
      r_ys        <= 9'd0;
      r_ye        <= 9'(V_RES - 1);
      r_x         <= 9'd0;
      r_y         <= 9'd0;
      o_cmd_valid <= 1'b0;
      o_cmd       <= 8'h00;
      o_pix_valid <= 1'b0;
      o_pix_x     <= 9'd0;
      o_pix_y     <= 9'd0;
      o_pix_color <= 16'h0000;
      o_err       <= 1'b0;
    end else begin
      o_cmd_valid <= w_is_cmd;
      o_pix_valid <= w_pix_fire;
      o_err       <= w_frag_err | (w_pix_fire & w_pix_oor);
      if (w_is_cmd) begin
        o_cmd <= w_byte;
        r_idx <= 2'd0;
        if (w_byte == CMD_RAMWR) begin
          r_x <= r_xs;
          r_y <= r_ys;
        end
      end else if (w_is_data) begin
        // Window bytes land immediately so a truncated sequence keeps them.
        case (r_state)
          ST_CASET: begin
            case (r_idx)
              2'd0:    r_xs[8]   <= w_byte[0];
              2'd1:    r_xs[7:0] <= w_byte;
              2'd2:    r_xe[8]   <= w_byte[0];
              default: r_xe[7:0] <= w_byte;
            endcase
            r_idx <= r_idx + 2'd1;
          end
          ST_PASET: begin
            case (r_idx)
              2'd0:    r_ys[8]   <= w_byte[0];
              2'd1:    r_ys[7:0] <= w_byte;
              2'd2:    r_ye[8]   <= w_byte[0];
              default: r_ye[7:0] <= w_byte;
            endcase
            r_idx <= r_idx + 2'd1;
          end
          ST_RAMWR: begin
            if (!r_idx[0]) begin
              r_col_hi <= w_byte;
              r_idx    <= 2'd1;
            end else begin
              o_pix_x     <= r_x;
              o_pix_y     <= r_y;
              o_pix_color <= {r_col_hi, w_byte};
              r_x         <= w_x_step;
              r_y         <= w_y_step;
              r_idx       <= 2'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_dbg = '{state: r_state, idx: r_idx, xs: r_xs, xe: r_xe,
                   ys: r_ys, ye: r_ye, x: r_x, y: r_y};

endmodule
